// File: rtl/mux_8to1_structural_if.sv
// mux_8to1_structural_if: data, select and result signals of the 8:1 mux
interface mux_8to1_structural_if;
  logic I0, I1, I2, I3, I4, I5, I6, I7;
  logic s0, s1, s2;
  logic Y;
  logic Y_q;
  logic [7:0] sel_oh;
  modport master (output I0, I1, I2, I3, I4, I5, I6, I7, s0, s1, s2, input Y, Y_q, sel_oh);
  modport slave (input I0, I1, I2, I3, I4, I5, I6, I7, s0, s1, s2, output Y, Y_q, sel_oh);
endinterface

// File: rtl/mux_8to1_structural.sv
// mux_8to1_structural: gate-level 8:1 mux with decoder, AND gating, OR tree and registered output
module mux_8to1_structural (
  input logic clk,
  input logic rst_n,
  mux_8to1_structural_if.slave bus
);
  logic s0_n, s1_n, s2_n;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic g0, g1, g2, g3, g4, g5, g6, g7;
  logic o01, o23, o45, o67, o0123, o4567, y;
  logic y_q;
  assign s0_n = ~bus.s0;
  assign s1_n = ~bus.s1;
  assign s2_n = ~bus.s2;
  assign d0 = s0_n & s1_n & s2_n;
  assign d1 = s0_n & s1_n & bus.s2;
  assign d2 = s0_n & bus.s1 & s2_n;
  assign d3 = s0_n & bus.s1 & bus.s2;
  assign d4 = bus.s0 & s1_n & s2_n;
  assign d5 = bus.s0 & s1_n & bus.s2;
  assign d6 = bus.s0 & bus.s1 & s2_n;
  assign d7 = bus.s0 & bus.s1 & bus.s2;
  assign g0 = bus.I0 & d0;
  assign g1 = bus.I1 & d1;
  assign g2 = bus.I2 & d2;
  assign g3 = bus.I3 & d3;
  assign g4 = bus.I4 & d4;
  assign g5 = bus.I5 & d5;
  assign g6 = bus.I6 & d6;
  assign g7 = bus.I7 & d7;
  assign o01 = g0 | g1;
  assign o23 = g2 | g3;
  assign o45 = g4 | g5;
  assign o67 = g6 | g7;
  assign o0123 = o01 | o23;
  assign o4567 = o45 | o67;
  assign y = o0123 | o4567;
  assign bus.Y = y;
  assign bus.sel_oh = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign bus.Y_q = y_q;
  // Registered copy of Y, cleared asynchronously while rst_n is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) y_q <= 1'b0;
    else y_q <= y;
endmodule

// File: tb/tb_mux_8to1_structural.sv
// tb_mux_8to1_structural: randomized and directed checks against an array-index reference model
module tb_mux_8to1_structural;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  mux_8to1_structural_if bus ();
  mux_8to1_structural dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] s);
    {bus.I7, bus.I6, bus.I5, bus.I4, bus.I3, bus.I2, bus.I1, bus.I0} = d;
    {bus.s0, bus.s1, bus.s2} = s;
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [7:0] d, input logic [2:0] s);
    check({tag, "_y"}, {7'd0, bus.Y}, {7'd0, d[s]});
    check({tag, "_oh"}, bus.sel_oh, 8'd1 << s);
  endtask

  logic [7:0] d;
  logic [2:0] s;
  logic [10:0] v;
  logic prev;

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 3'd0);
    check("reset_yq", {7'd0, bus.Y_q}, 8'd0);
    check("reset_y", {7'd0, bus.Y}, 8'd0);
    drive(8'h02, 3'd1);
    check("noclk_i1", {7'd0, bus.Y}, 8'd1);
    drive(8'h10, 3'd4);
    check("noclk_i4", {7'd0, bus.Y}, 8'd1);
    drive(8'h02, 3'd4);
    check("i1_sel4", {7'd0, bus.Y}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(8'd1 << k, 3'(k));
      check_comb("walk", 8'd1 << k, 3'(k));
      #9;
    end
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) begin
        drive(8'd1 << k, 3'(j));
        check_comb(j == k ? "desel_hit" : "desel", 8'd1 << k, 3'(j));
      end
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++) begin
        drive(~(8'd1 << k), 3'(j));
        check_comb("inverse", ~(8'd1 << k), 3'(j));
      end
    for (int i = 0; i < 2048; i++) begin
      v = 11'(i);
      drive(v[7:0], v[10:8]);
      d = v[7:0];
      check("sweep", {7'd0, bus.Y}, {7'd0, d[v[10:8]]});
    end
    @(negedge clk);
    drive(8'h00, 3'd3);
    @(posedge clk);
    #1 check("lat_low", {7'd0, bus.Y_q}, 8'd0);
    @(negedge clk);
    drive(8'h08, 3'd3);
    check("lat_y_now", {7'd0, bus.Y}, 8'd1);
    check("lat_yq_hold", {7'd0, bus.Y_q}, 8'd0);
    @(posedge clk);
    #1 check("lat_yq_rise", {7'd0, bus.Y_q}, 8'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("areset_yq", {7'd0, bus.Y_q}, 8'd0);
    check("areset_y", {7'd0, bus.Y}, 8'd1);
    @(posedge clk);
    #1 check("areset_hold", {7'd0, bus.Y_q}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_pre", {7'd0, bus.Y_q}, 8'd0);
    @(posedge clk);
    #1 check("release_load", {7'd0, bus.Y_q}, 8'd1);
    repeat (300) begin
      @(negedge clk);
      d = 8'($urandom);
      s = 3'($urandom);
      drive(d, s);
      check_comb("rand", d, s);
      prev = d[s];
      @(posedge clk);
      #1 check("rand_yq", {7'd0, bus.Y_q}, {7'd0, prev});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
